// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op codes, FSM states and default sizes for the operand stack
package stack_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 32;
  localparam int PTR_W_DEF  = 5;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CAP,
    S_ACK
  } state_t;

endpackage

// File: rtl/stack_unit_if.sv
// rtl/stack_unit_if.sv - request/acknowledge bundle between the control unit and the operand stack
interface stack_unit_if #(
  parameter int DATA_W = stack_pkg::DATA_W_DEF,
  parameter int PTR_W  = stack_pkg::PTR_W_DEF
);

  logic              req;
  logic [1:0]        op;
  logic              src_sel;
  logic [DATA_W-1:0] din_uc;
  logic [DATA_W-1:0] din_alu;
  logic              clr_err;
  logic              ack;
  logic              busy;
  logic [DATA_W-1:0] q_data;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output req, op, src_sel, din_uc, din_alu, clr_err,
    input  ack, busy, q_data, count, full, empty, overflow_err, underflow_err
  );

  modport slave (
    input  req, op, src_sel, din_uc, din_alu, clr_err,
    output ack, busy, q_data, count, full, empty, overflow_err, underflow_err
  );

endinterface

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - single-port synchronous RAM with registered read, array not reset
module stack_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - operand stack: handshake FSM, stack pointer and sticky error flags around stack_ram
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input logic         clock,
  input logic         reset,
  stack_unit_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_q;
  logic [PTR_W:0]    r_count;
  logic              r_ovf;
  logic              r_unf;

  logic              w_full;
  logic              w_empty;
  logic [PTR_W:0]    w_cnt_dec;
  logic              w_set_ovf;
  logic              w_set_unf;
  logic              w_we;
  logic [PTR_W-1:0]  w_addr;
  logic [DATA_W-1:0] w_rdata;

  assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_cnt_dec = r_count - (PTR_W+1)'(1);

  always_comb begin
    w_next    = r_state;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    w_we      = 1'b0;
    w_addr    = r_count[PTR_W-1:0];
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          case (bus.op)
            OP_PUSH: begin
              if (w_full) begin
                w_next    = S_ACK;
                w_set_ovf = 1'b1;
              end else begin
                w_next = S_WR;
              end
            end
            OP_POP, OP_PEEK: begin
              if (w_empty) begin
                w_next    = S_ACK;
                w_set_unf = 1'b1;
              end else begin
                w_next = S_RD;
              end
            end
            default: w_next = S_ACK;
          endcase
        end
      end
      // a reset landing on the write edge must not commit the write
      S_WR: begin
        w_we   = !reset;
        w_next = S_ACK;
      end
      S_RD: begin
        w_addr = w_cnt_dec[PTR_W-1:0];
        w_next = S_CAP;
      end
      S_CAP:   w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_q     <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WR) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end
      if (r_state == S_RD && r_op == OP_POP) begin
        r_count <= w_cnt_dec;
      end
      if (r_state == S_CAP) begin
        r_q <= w_rdata;
      end
      // a new error on the same edge as clr_err keeps the flag set
      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_err) begin
        r_ovf <= 1'b0;
      end
      if (w_set_unf) begin
        r_unf <= 1'b1;
      end else if (bus.clr_err) begin
        r_unf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == S_IDLE && bus.req) begin
      r_op   <= bus.op;
      r_data <= bus.src_sel ? bus.din_alu : bus.din_uc;
    end
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (r_data),
    .o_rdata (w_rdata)
  );

  assign bus.ack           = (r_state == S_ACK);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.q_data        = r_q;
  assign bus.count         = r_count;
  assign bus.full          = w_full;
  assign bus.empty         = w_empty;
  assign bus.overflow_err  = r_ovf;
  assign bus.underflow_err = r_unf;

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - directed self-checking bench for stack_unit
module tb_stack_unit;
  import stack_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  stack_unit_if #(.DATA_W(16), .PTR_W(5)) bus ();

  stack_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // drives one request, returns edges from accept to ack (99 if ack never came), leaves bus idle
  task automatic do_op(input logic [1:0] op_v, input logic src, input logic [15:0] uc,
                       input logic [15:0] alu, input logic clr, output int lat);
    bus.req = 1'b1; bus.op = op_v; bus.src_sel = src; bus.din_uc = uc; bus.din_alu = alu;
    bus.clr_err = clr;
    @(posedge clock); #1;
    bus.req = 1'b0; bus.clr_err = 1'b0;
    lat = 1;
    while (!bus.ack && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!bus.ack) lat = 99;
    @(posedge clock); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    bus.req = 1'b0; bus.op = OP_PUSH; bus.src_sel = 1'b0; bus.din_uc = '0; bus.din_alu = '0;
    bus.clr_err = 1'b0;
    apply_reset();
    vectors++; if (bus.count !== 6'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", bus.count); end
    vectors++; if ({bus.empty, bus.full, bus.busy, bus.ack} !== 4'b1000) begin miscompares++; $display("FAIL rst_status got %b want 1000", {bus.empty, bus.full, bus.busy, bus.ack}); end
    vectors++; if (bus.q_data !== 16'h0000) begin miscompares++; $display("FAIL rst_q got %h want 0000", bus.q_data); end
    vectors++; if ({bus.overflow_err, bus.underflow_err} !== 2'b00) begin miscompares++; $display("FAIL rst_err got %b want 00", {bus.overflow_err, bus.underflow_err}); end
    do_op(OP_PUSH, 1'b0, 16'h0005, 16'hDEAD, 1'b0, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL push_lat got %0d want 2", lat); end
    vectors++; if (bus.count !== 6'd1 || bus.empty !== 1'b0) begin miscompares++; $display("FAIL push_count got %0d/%b want 1/0", bus.count, bus.empty); end
  endtask

  task automatic test_alu_push_pop();
    int lat;
    do_op(OP_PUSH, 1'b1, 16'hBEEF, 16'h00A3, 1'b0, lat);
    vectors++; if (bus.count !== 6'd2) begin miscompares++; $display("FAIL alu_push_count got %0d want 2", bus.count); end
    do_op(OP_POP, 1'b0, 16'h0000, 16'h0000, 1'b0, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL pop_lat got %0d want 3", lat); end
    vectors++; if (bus.q_data !== 16'h00A3) begin miscompares++; $display("FAIL pop_q got %h want 00a3", bus.q_data); end
    vectors++; if (bus.count !== 6'd1) begin miscompares++; $display("FAIL pop_count got %0d want 1", bus.count); end
    do_op(OP_POP, 1'b0, 16'h0000, 16'h0000, 1'b0, lat);
    vectors++; if (bus.q_data !== 16'h0005) begin miscompares++; $display("FAIL pop2_q got %h want 0005", bus.q_data); end
  endtask

  task automatic test_peek();
    int lat;
    apply_reset();
    do_op(OP_PUSH, 1'b0, 16'h0011, 16'h0000, 1'b0, lat);
    do_op(OP_PUSH, 1'b0, 16'h0022, 16'h0000, 1'b0, lat);
    do_op(OP_PEEK, 1'b0, 16'h0000, 16'h0000, 1'b0, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL peek_lat got %0d want 3", lat); end
    vectors++; if (bus.q_data !== 16'h0022 || bus.count !== 6'd2) begin miscompares++; $display("FAIL peek got %h/%0d want 0022/2", bus.q_data, bus.count); end
    do_op(OP_POP, 1'b0, 16'h0000, 16'h0000, 1'b0, lat);
    vectors++; if (bus.q_data !== 16'h0022 || bus.count !== 6'd1) begin miscompares++; $display("FAIL peek_pop got %h/%0d want 0022/1", bus.q_data, bus.count); end
    do_op(OP_RSVD, 1'b0, 16'h0000, 16'h0000, 1'b0, lat);
    vectors++; if (lat !== 1 || bus.count !== 6'd1 || bus.q_data !== 16'h0022) begin miscompares++; $display("FAIL rsvd got lat %0d cnt %0d q %h want 1/1/0022", lat, bus.count, bus.q_data); end
  endtask

  task automatic test_overflow();
    int lat;
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      do_op(OP_PUSH, 1'b0, 16'h0100 + 16'(i), 16'h0000, 1'b0, lat);
    end
    vectors++; if (bus.count !== 6'd32 || bus.full !== 1'b1) begin miscompares++; $display("FAIL fill got %0d/%b want 32/1", bus.count, bus.full); end
    do_op(OP_PUSH, 1'b0, 16'hFFFF, 16'h0000, 1'b0, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL ovf_lat got %0d want 1", lat); end
    vectors++; if ({bus.overflow_err, bus.full} !== 2'b11 || bus.count !== 6'd32) begin miscompares++; $display("FAIL ovf got %b/%0d want 11/32", {bus.overflow_err, bus.full}, bus.count); end
    do_op(OP_POP, 1'b0, 16'h0000, 16'h0000, 1'b0, lat);
    vectors++; if (bus.q_data !== 16'h011F || bus.count !== 6'd31 || bus.full !== 1'b0) begin miscompares++; $display("FAIL ovf_pop got %h/%0d/%b want 011f/31/0", bus.q_data, bus.count, bus.full); end
    bus.clr_err = 1'b1; @(posedge clock); #1; bus.clr_err = 1'b0;
    vectors++; if (bus.overflow_err !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got %b want 0", bus.overflow_err); end
  endtask

  task automatic test_underflow();
    int lat;
    apply_reset();
    do_op(OP_PUSH, 1'b0, 16'h1234, 16'h0000, 1'b0, lat);
    do_op(OP_POP, 1'b0, 16'h0000, 16'h0000, 1'b0, lat);
    do_op(OP_POP, 1'b0, 16'h0000, 16'h0000, 1'b0, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL unf_lat got %0d want 1", lat); end
    vectors++; if (bus.underflow_err !== 1'b1 || bus.q_data !== 16'h1234 || bus.count !== 6'd0) begin miscompares++; $display("FAIL unf got %b/%h/%0d want 1/1234/0", bus.underflow_err, bus.q_data, bus.count); end
    bus.clr_err = 1'b1; @(posedge clock); #1; bus.clr_err = 1'b0;
    vectors++; if (bus.underflow_err !== 1'b0) begin miscompares++; $display("FAIL unf_clr got %b want 0", bus.underflow_err); end
    do_op(OP_PEEK, 1'b0, 16'h0000, 16'h0000, 1'b1, lat);
    vectors++; if (bus.underflow_err !== 1'b1) begin miscompares++; $display("FAIL unf_clr_race got %b want 1", bus.underflow_err); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int acks;
    apply_reset();
    do_op(OP_PUSH, 1'b0, 16'h0A0A, 16'h0000, 1'b0, lat);
    do_op(OP_PUSH, 1'b0, 16'h0B0B, 16'h0000, 1'b0, lat);
    do_op(OP_PUSH, 1'b0, 16'h0C0C, 16'h0000, 1'b0, lat);
    bus.req = 1'b1; bus.op = OP_POP;
    @(posedge clock); #1; bus.req = 1'b0;
    @(posedge clock); #1;
    vectors++; if (bus.busy !== 1'b1 || bus.ack !== 1'b0) begin miscompares++; $display("FAIL cap_busy got %b/%b want 1/0", bus.busy, bus.ack); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.ack) acks++;
      @(posedge clock); #1;
    end
    vectors++; if (acks !== 0) begin miscompares++; $display("FAIL abort_ack got %0d acks want 0", acks); end
    vectors++; if (bus.count !== 6'd0 || bus.q_data !== 16'h0000 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort got %0d/%h/%b want 0/0000/0", bus.count, bus.q_data, bus.busy); end
  endtask

  task automatic test_req_while_busy();
    int lat;
    bus.req = 1'b1; bus.op = OP_PUSH; bus.src_sel = 1'b0; bus.din_uc = 16'h0777;
    @(posedge clock); #1;
    bus.din_uc = 16'h0999;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL busy_wr got %b want 1", bus.busy); end
    @(posedge clock); #1;
    vectors++; if (bus.ack !== 1'b1) begin miscompares++; $display("FAIL busy_ack got %b want 1", bus.ack); end
    bus.req = 1'b0;
    @(posedge clock); #1;
    vectors++; if (bus.count !== 6'd1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_count got %0d/%b want 1/0", bus.count, bus.busy); end
    do_op(OP_POP, 1'b0, 16'h0000, 16'h0000, 1'b0, lat);
    vectors++; if (bus.q_data !== 16'h0777 || bus.count !== 6'd0) begin miscompares++; $display("FAIL busy_pop got %h/%0d want 0777/0", bus.q_data, bus.count); end
  endtask

  initial begin
    test_reset();
    test_alu_push_pop();
    test_peek();
    test_overflow();
    test_underflow();
    test_reset_mid_op();
    test_req_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
